control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit that drives the datapath's register enables, bus selects, memory read/write and ALU opcode. It runs the instruction fetch (T0–T2) and the per-opcode execute steps. It replaces the hand-sequenced control-signal waveforms currently written by hand in the memory-subsystem benches, and sits directly beside `datapath`, one output per datapath control input.

## Interface
- No parameters.
- `clk` in 1: rising-edge system clock.
- `reset` in 1: asynchronous, active-high; forces state RESET and all outputs to 0.
- `IR_Data` in 32: instruction register contents.
  - Opcode `[31:27]`, Ra `[26:23]`, Rb `[22:19]`, Rc `[18:15]`, C `[18:0]`.
- `stop` in 1: pause request, sampled at instruction boundaries.
- `PC_select`, `MAR_enable`, `PC_increment_enable`, `read`, `write`, `MDR_enable`, `MDR_select`, `IR_enable` out 1 each: fetch/memory controls.
- `Gra`, `Grb`, `Grc`, `ba_select`, `r_out`, `r_enable` out 1 each: register-file select/encode controls.
  - `ba_select` drives the base-address bus (R0 reads as 0).
  - `r_out` drives the selected register onto the bus unchanged.
- `Y_enable`, `Z_enable`, `Z_LO_select`, `c_select` out 1 each: ALU path controls.
- `alu_instruction` out 5: ALU opcode.
  - add = `00001`, sub = `00010`, and = `00011`, or = `00100`, idle = `00000`.
- `run` out 1: 1 while executing; 0 in RESET, STOP, HALT.

## Operation
- One state per clock. Outputs are combinational decodes of the current state, plus `IR_Data[31:27]` in states T3–T7.
- Any output not listed for a state is 0.
- Fetch, common to all opcodes:
  - T0: `PC_select`, `MAR_enable`.
  - T1: `PC_increment_enable`, `read`, `MDR_enable`.
  - T2: `MDR_select`, `IR_enable`. IR is loaded at the T2→T3 edge and is stable from T3 on.
- Opcode `00001`, ldi:
  - T3: `Grb`, `ba_select`, `Y_enable`.
  - T4: `c_select`, `alu_instruction` = `00001`, `Z_enable`.
  - T5: `Z_LO_select`, `Gra`, `r_enable`. Last step.
- Opcode `00000`, ld:
  - T3–T4: same as ldi.
  - T5: `Z_LO_select`, `MAR_enable`.
  - T6: `read`, `MDR_enable`.
  - T7: `MDR_select`, `Gra`, `r_enable`. Last step.
- Opcode `00010`, st:
  - T3–T5: same as ld.
  - T6: `Gra`, `r_out`, `MDR_enable`, with `read` = 0.
  - T7: `write`. Last step.
- Opcodes `00011` add, `00100` sub, `00101` and, `00110` or:
  - T3: `Grb`, `r_out`, `Y_enable`.
  - T4: `Grc`, `r_out`, `Z_enable`, `alu_instruction` = `00001` / `00010` / `00011` / `00100` respectively.
  - T5: `Z_LO_select`, `Gra`, `r_enable`. Last step.
- Opcode `11011`, halt: T3 → HALT. HALT is terminal; only `reset` leaves it.
- Any other opcode: T3 is a no-op (all outputs 0) and is the last step.
- Transitions:
  - RESET → T0 on the first clock after `reset` falls.
  - T0 → T1 → T2 → T3, then through the execute states for the opcode.
  - Last step → T0 if `stop` = 0; → STOP if `stop` = 1.
  - STOP → T0 when `stop` = 0. STOP holds while `stop` = 1.
- `reset` asserted mid-instruction aborts it immediately. No partial write completes after the asynchronous reset.

## Timing
- Reset values: every output 0, including `run`; state RESET.
- `run` = 1 in T0–T7.
- Cycle counts, fetch included:
  - ldi and ALU ops: 6 cycles.
  - ld and st: 8 cycles.
  - Unknown opcode: 4 cycles.
  - halt: 4 cycles to reach HALT.
- `read` and `write` are never asserted in the same cycle.
- `r_enable` is never asserted in the same cycle as `r_out` or `ba_select`.
- At most one bus driver is active per cycle: `PC_select`, `MDR_select`, `Z_LO_select`, `c_select`, `r_out`, `ba_select`.
- `stop` affects only the last-step transition. Asserting it mid-instruction does not shorten the instruction.
- `IR_Data` changes outside T2→T3 must not affect outputs in T0–T2.

## Test plan
- **Reset mid-instruction.** Assert `reset` during ld T6 → all outputs 0 asynchronously, `run` = 0. Release `reset` → T0 (`PC_select` = `MAR_enable` = 1) on the next clock.
- **ldi.** Load `IR_Data` = `0x09080005` (ldi R2, R1, 5) at the T2 edge → T3 `Grb`/`ba_select`/`Y_enable`; T4 `alu_instruction` = `00001`, `c_select`, `Z_enable`; T5 `Gra`/`r_enable`/`Z_LO_select`. T0 follows 6 cycles after the prior T0.
- **ld and st.** IR opcode `00000`, then `00010` → 8-cycle sequences. For ld, `read` = 1 in T1 and T6 only. For st, `write` = 1 in T7 only, and `read` = 0 in T6.
- **sub.** IR opcode `00100` → T3 `Grb` + `r_out`; T4 `Grc` + `r_out` + `alu_instruction` = `00010`; T5 `Gra` + `r_enable`.
- **stop.** Raise `stop` during ldi T4 → ldi completes, state goes to STOP with `run` = 0. Drop `stop` → T0 next clock.
- **halt and unknown opcode.** IR opcode `11011` → HALT, `run` held 0 for 20 cycles. Opcode `11111` → no-op T3, then T0.
- **All tests:** check the single-bus-driver rule every cycle.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the datapath.
// The sequencer is the master: it reads IR/stop and drives every datapath control.
interface control_sequencer_if;
  logic [31:0] IR_Data;
  logic        stop;

  logic        PC_select;
  logic        MAR_enable;
  logic        PC_increment_enable;
  logic        read;
  logic        write;
  logic        MDR_enable;
  logic        MDR_select;
  logic        IR_enable;

  logic        Gra;
  logic        Grb;
  logic        Grc;
  logic        ba_select;
  logic        r_out;
  logic        r_enable;

  logic        Y_enable;
  logic        Z_enable;
  logic        Z_LO_select;
  logic        c_select;
  logic [4:0]  alu_instruction;

  logic        run;

  modport master (
    input  IR_Data, stop,
    output PC_select, MAR_enable, PC_increment_enable, read, write,
           MDR_enable, MDR_select, IR_enable,
           Gra, Grb, Grc, ba_select, r_out, r_enable,
           Y_enable, Z_enable, Z_LO_select, c_select, alu_instruction, run
  );

  modport slave (
    output IR_Data, stop,
    input  PC_select, MAR_enable, PC_increment_enable, read, write,
           MDR_enable, MDR_select, IR_enable,
           Gra, Grb, Grc, ba_select, r_out, r_enable,
           Y_enable, Z_enable, Z_LO_select, c_select, alu_instruction, run
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit: instruction fetch (T0-T2) plus per-opcode execute steps.
// Outputs are a combinational decode of the current state and, from T3 on, the opcode.
module control_sequencer (
  input  logic                       clk,
  input  logic                       reset,
  control_sequencer_if.master        bus
);

  localparam int unsigned OP_W  = 5;
  localparam int unsigned ALU_W = 5;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  localparam logic [ALU_W-1:0] ALU_IDLE = 5'b00000;
  localparam logic [ALU_W-1:0] ALU_ADD  = 5'b00001;
  localparam logic [ALU_W-1:0] ALU_SUB  = 5'b00010;
  localparam logic [ALU_W-1:0] ALU_AND  = 5'b00011;
  localparam logic [ALU_W-1:0] ALU_OR   = 5'b00100;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_STOP  = 4'd9,
    S_HALT  = 4'd10
  } state_e;

  state_e            state_q, state_d;
  logic [OP_W-1:0]   opcode;
  logic              is_ld, is_ldi, is_st, is_mem, is_alu;
  logic [ALU_W-1:0]  alu_code;
  logic              last_step;

  assign opcode = bus.IR_Data[31:27];
  assign is_ld  = (opcode == OP_LD);
  assign is_ldi = (opcode == OP_LDI);
  assign is_st  = (opcode == OP_ST);
  assign is_mem = is_ld | is_ldi | is_st;
  assign is_alu = (opcode == OP_ADD) | (opcode == OP_SUB) |
                  (opcode == OP_AND) | (opcode == OP_OR);

  // ALU-format opcode to ALU function code
  always_comb begin
    alu_code = ALU_IDLE;
    case (opcode)
      OP_ADD:  alu_code = ALU_ADD;
      OP_SUB:  alu_code = ALU_SUB;
      OP_AND:  alu_code = ALU_AND;
      OP_OR:   alu_code = ALU_OR;
      default: alu_code = ALU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d                 = state_q;
    last_step               = 1'b0;
    bus.PC_select           = 1'b0;
    bus.MAR_enable          = 1'b0;
    bus.PC_increment_enable = 1'b0;
    bus.read                = 1'b0;
    bus.write               = 1'b0;
    bus.MDR_enable          = 1'b0;
    bus.MDR_select          = 1'b0;
    bus.IR_enable           = 1'b0;
    bus.Gra                 = 1'b0;
    bus.Grb                 = 1'b0;
    bus.Grc                 = 1'b0;
    bus.ba_select           = 1'b0;
    bus.r_out               = 1'b0;
    bus.r_enable            = 1'b0;
    bus.Y_enable            = 1'b0;
    bus.Z_enable            = 1'b0;
    bus.Z_LO_select         = 1'b0;
    bus.c_select            = 1'b0;
    bus.alu_instruction     = ALU_IDLE;
    bus.run                 = 1'b0;

    case (state_q)
      S_RESET: state_d = S_T0;

      S_T0: begin
        bus.run        = 1'b1;
        bus.PC_select  = 1'b1;
        bus.MAR_enable = 1'b1;
        state_d        = S_T1;
      end

      S_T1: begin
        bus.run                 = 1'b1;
        bus.PC_increment_enable = 1'b1;
        bus.read                = 1'b1;
        bus.MDR_enable          = 1'b1;
        state_d                 = S_T2;
      end

      S_T2: begin
        bus.run        = 1'b1;
        bus.MDR_select = 1'b1;
        bus.IR_enable  = 1'b1;
        state_d        = S_T3;
      end

      S_T3: begin
        bus.run = 1'b1;
        if (is_mem) begin
          bus.Grb       = 1'b1;
          bus.ba_select = 1'b1;
          bus.Y_enable  = 1'b1;
          state_d       = S_T4;
        end else if (is_alu) begin
          bus.Grb      = 1'b1;
          bus.r_out    = 1'b1;
          bus.Y_enable = 1'b1;
          state_d      = S_T4;
        end else if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          last_step = 1'b1;
        end
      end

      S_T4: begin
        bus.run = 1'b1;
        if (is_mem) begin
          bus.c_select        = 1'b1;
          bus.alu_instruction = ALU_ADD;
          bus.Z_enable        = 1'b1;
          state_d             = S_T5;
        end else if (is_alu) begin
          bus.Grc             = 1'b1;
          bus.r_out           = 1'b1;
          bus.Z_enable        = 1'b1;
          bus.alu_instruction = alu_code;
          state_d             = S_T5;
        end else begin
          last_step = 1'b1;
        end
      end

      S_T5: begin
        bus.run = 1'b1;
        if (is_ldi || is_alu) begin
          bus.Z_LO_select = 1'b1;
          bus.Gra         = 1'b1;
          bus.r_enable    = 1'b1;
          last_step       = 1'b1;
        end else if (is_ld || is_st) begin
          bus.Z_LO_select = 1'b1;
          bus.MAR_enable  = 1'b1;
          state_d         = S_T6;
        end else begin
          last_step = 1'b1;
        end
      end

      S_T6: begin
        bus.run = 1'b1;
        if (is_ld) begin
          bus.read       = 1'b1;
          bus.MDR_enable = 1'b1;
          state_d        = S_T7;
        end else if (is_st) begin
          bus.Gra        = 1'b1;
          bus.r_out      = 1'b1;
          bus.MDR_enable = 1'b1;
          state_d        = S_T7;
        end else begin
          last_step = 1'b1;
        end
      end

      S_T7: begin
        bus.run   = 1'b1;
        last_step = 1'b1;
        if (is_ld) begin
          bus.MDR_select = 1'b1;
          bus.Gra        = 1'b1;
          bus.r_enable   = 1'b1;
        end else if (is_st) begin
          bus.write = 1'b1;
        end
      end

      S_STOP: begin
        if (!bus.stop) state_d = S_T0;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_RESET;
    endcase

    // stop is only honoured at the instruction boundary
    if (last_step) state_d = bus.stop ? S_STOP : S_T0;
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus pushes the hand-derived control
// vector for each cycle; a negedge monitor pops and compares it and checks bus rules.
module tb_control_sequencer;

  logic clk;
  logic reset;
  control_sequencer_if bus ();

  control_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector bit masks
  localparam logic [23:0] PCS  = 24'h000001;
  localparam logic [23:0] MARE = 24'h000002;
  localparam logic [23:0] PCI  = 24'h000004;
  localparam logic [23:0] RD   = 24'h000008;
  localparam logic [23:0] WR   = 24'h000010;
  localparam logic [23:0] MDRE = 24'h000020;
  localparam logic [23:0] MDRS = 24'h000040;
  localparam logic [23:0] IRE  = 24'h000080;
  localparam logic [23:0] GRA  = 24'h000100;
  localparam logic [23:0] GRB  = 24'h000200;
  localparam logic [23:0] GRC  = 24'h000400;
  localparam logic [23:0] BAS  = 24'h000800;
  localparam logic [23:0] ROUT = 24'h001000;
  localparam logic [23:0] REN  = 24'h002000;
  localparam logic [23:0] YE   = 24'h004000;
  localparam logic [23:0] ZE   = 24'h008000;
  localparam logic [23:0] ZLO  = 24'h010000;
  localparam logic [23:0] CS   = 24'h020000;
  localparam logic [23:0] ALU1 = 24'h040000;
  localparam logic [23:0] ALU2 = 24'h080000;
  localparam logic [23:0] ALU3 = 24'h0C0000;
  localparam logic [23:0] ALU4 = 24'h100000;
  localparam logic [23:0] RUN  = 24'h800000;
  localparam logic [23:0] NONE = 24'h000000;

  localparam logic [31:0] IR_LDI  = 32'h09080005;
  localparam logic [31:0] IR_LD   = 32'h01100010;
  localparam logic [31:0] IR_ST   = 32'h10900020;
  localparam logic [31:0] IR_ADD  = 32'h19110000;
  localparam logic [31:0] IR_SUB  = 32'h21110000;
  localparam logic [31:0] IR_AND  = 32'h29110000;
  localparam logic [31:0] IR_OR   = 32'h31110000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;
  localparam logic [31:0] IR_UNK  = 32'hF8000000;

  logic [23:0] act;
  assign act = {bus.run, bus.alu_instruction, bus.c_select, bus.Z_LO_select,
                bus.Z_enable, bus.Y_enable, bus.r_enable, bus.r_out, bus.ba_select,
                bus.Grc, bus.Grb, bus.Gra, bus.IR_enable, bus.MDR_select,
                bus.MDR_enable, bus.write, bus.read, bus.PC_increment_enable,
                bus.MAR_enable, bus.PC_select};

  logic [23:0] exp_q [$];
  string       tag_q [$];
  int          total = 0;
  int          bad   = 0;

  // Monitor: one expected vector per cycle, plus bus-rule checks every cycle
  always @(negedge clk) begin
    int drivers;
    if (exp_q.size() > 0) begin
      logic [23:0] e;
      string       t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %06h expected %06h", t, act, e);
      end
    end
    drivers = int'(bus.PC_select) + int'(bus.MDR_select) + int'(bus.Z_LO_select) +
              int'(bus.c_select) + int'(bus.r_out) + int'(bus.ba_select);
    total++;
    if (drivers > 1) begin
      bad++;
      $display("FAIL bus_drivers: got %0d active, expected at most 1", drivers);
    end
    total++;
    if (bus.read && bus.write) begin
      bad++;
      $display("FAIL read_write: got read=1 write=1, expected not both");
    end
    total++;
    if (bus.r_enable && (bus.r_out || bus.ba_select)) begin
      bad++;
      $display("FAIL renable_conflict: got r_enable=1 r_out=%0b ba_select=%0b, expected none",
               bus.r_out, bus.ba_select);
    end
  end

  task automatic cyc(input logic [31:0] ir, input logic stp, input logic [23:0] e,
                     input string t);
    @(posedge clk);
    #1;
    bus.IR_Data = ir;
    bus.stop    = stp;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  // Fetch with unrelated IR contents to show T0-T2 ignore IR_Data
  task automatic fetch(input logic stp);
    cyc($urandom, stp, RUN | PCS | MARE, "T0");
    cyc($urandom, stp, RUN | PCI | RD | MDRE, "T1");
    cyc($urandom, stp, RUN | MDRS | IRE, "T2");
  endtask

  task automatic run_ldi(input logic stp4, input logic stp5);
    fetch(1'b0);
    cyc(IR_LDI, 1'b0, RUN | GRB | BAS | YE, "ldi_T3");
    cyc(IR_LDI, stp4, RUN | CS | ALU1 | ZE, "ldi_T4");
    cyc(IR_LDI, stp5, RUN | ZLO | GRA | REN, "ldi_T5");
  endtask

  task automatic run_alu(input logic [31:0] ir, input logic [23:0] alu, input string t);
    fetch(1'b1);
    cyc(ir, 1'b1, RUN | GRB | ROUT | YE, {t, "_T3"});
    cyc(ir, 1'b1, RUN | GRC | ROUT | ZE | alu, {t, "_T4"});
    cyc(ir, 1'b0, RUN | ZLO | GRA | REN, {t, "_T5"});
  endtask

  task automatic run_ld_to_t5();
    fetch(1'b0);
    cyc(IR_LD, 1'b0, RUN | GRB | BAS | YE, "ld_T3");
    cyc(IR_LD, 1'b0, RUN | CS | ALU1 | ZE, "ld_T4");
    cyc(IR_LD, 1'b0, RUN | ZLO | MARE, "ld_T5");
  endtask

  initial begin
    reset       = 1'b1;
    bus.IR_Data = 32'h0;
    bus.stop    = 1'b0;

    @(posedge clk);
    #1;
    exp_q.push_back(NONE); tag_q.push_back("reset_state");
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.push_back(NONE); tag_q.push_back("reset_released");

    run_ldi(1'b0, 1'b0);

    run_ld_to_t5();
    cyc(IR_LD, 1'b0, RUN | RD | MDRE, "ld_T6");
    cyc(IR_LD, 1'b0, RUN | MDRS | GRA | REN, "ld_T7");

    fetch(1'b0);
    cyc(IR_ST, 1'b0, RUN | GRB | BAS | YE, "st_T3");
    cyc(IR_ST, 1'b0, RUN | CS | ALU1 | ZE, "st_T4");
    cyc(IR_ST, 1'b0, RUN | ZLO | MARE, "st_T5");
    cyc(IR_ST, 1'b0, RUN | GRA | ROUT | MDRE, "st_T6");
    cyc(IR_ST, 1'b0, RUN | WR, "st_T7");

    // stop held high mid-instruction must not shorten it
    run_alu(IR_SUB, ALU2, "sub");
    run_alu(IR_ADD, ALU1, "add");
    run_alu(IR_AND, ALU3, "and");
    run_alu(IR_OR,  ALU4, "or");

    run_ldi(1'b1, 1'b1);
    cyc(IR_LDI, 1'b1, NONE, "stop_hold");
    cyc(IR_LDI, 1'b0, NONE, "stop_release");

    fetch(1'b0);
    cyc(IR_UNK, 1'b0, RUN, "unknown_T3");

    run_ld_to_t5();
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.push_back(NONE); tag_q.push_back("reset_mid_ld");
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.push_back(NONE); tag_q.push_back("reset_mid_ld_held");

    fetch(1'b0);
    cyc(IR_HALT, 1'b0, RUN, "halt_T3");
    for (int i = 0; i < 20; i++) cyc($urandom, 1'($urandom_range(0, 1)), NONE, "halt_hold");

    @(posedge clk);
    #1;
    bus.stop = 1'b0;
    @(negedge clk);
    @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
